step_alu_cpu: RTL and testbench

STEP_ALU_CPU -- requirements
Module: step_alu_cpu

---
 rtl/step_alu_cpu_pkg.sv | 36 +++
 rtl/step_alu_cpu_core.sv | 47 ++++
 rtl/step_alu_cpu.sv | 189 ++++++++++++++++++
 tb/tb_step_alu_cpu.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/step_alu_cpu_pkg.sv
// Shared opcode constants, sequencer state type and instruction-field offsets
// for step_alu_cpu.
package step_alu_cpu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHL  = 4'h6;
    localparam logic [3:0] OP_SHR  = 4'h7;
    localparam logic [3:0] OP_MUL  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_DONE
    } state_e;

    // Instruction word layout is {opcode[3:0], A[w-1:0], B[w-1:0]}.
    function automatic int op_lsb(input int w);
        return 2 * w;
    endfunction

    function automatic int a_lsb(input int w);
        return w;
    endfunction

    function automatic int b_lsb(input int w);
        return 0 * w;
    endfunction

endpackage

// File: rtl/step_alu_cpu_core.sv
// Combinational ALU for opcodes 0-7; every other opcode yields zero result and flags.
module step_alu_core
    import step_alu_cpu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_o,
    output logic             carry_o,
    output logic             borrow_o
);

    logic [WIDTH:0] sum;

    always_comb begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        res_o    = '0;
        carry_o  = 1'b0;
        borrow_o = 1'b0;
        case (op_i)
            OP_ADD: begin
                res_o   = sum[WIDTH-1:0];
                carry_o = sum[WIDTH];
            end
            OP_SUB: begin
                res_o    = a_i - b_i;
                borrow_o = (a_i < b_i);
            end
            OP_AND: res_o = a_i & b_i;
            OP_OR:  res_o = a_i | b_i;
            OP_XOR: res_o = a_i ^ b_i;
            OP_NOT: res_o = ~a_i;
            OP_SHL: begin
                res_o   = {a_i[WIDTH-2:0], 1'b0};
                carry_o = a_i[WIDTH-1];
            end
            OP_SHR: begin
                res_o   = {1'b0, a_i[WIDTH-1:1]};
                carry_o = a_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/step_alu_cpu.sv
// Single-step ALU processor: IDLE -> FETCH -> EXEC -> DONE per rising edge of next_out.
// Define STEP_ALU_CPU_MUL_EN to add a WIDTH-step shift-add multiplier for opcode 8.
module step_alu_cpu
    import step_alu_cpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int PC_W = $clog2(DEPTH),
    localparam int IW   = 4 + 2 * WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             next_out,
    input  logic             prog_we,
    input  logic [PC_W-1:0]  prog_addr,
    input  logic [IW-1:0]    prog_data,
    output logic [3:0]       opcode,
    output logic [WIDTH-1:0] operand_A_out,
    output logic [WIDTH-1:0] operand_B_out,
    output logic [WIDTH-1:0] result_out,
    output logic             carry_out,
    output logic             borrow_out,
    output logic             data_out,
    output logic             result_ready,
    output logic [PC_W-1:0]  pc_out,
    output logic             halted
);

    localparam int OP_L = op_lsb(WIDTH);
    localparam int A_L  = a_lsb(WIDTH);
    localparam int B_L  = b_lsb(WIDTH);

    state_e            state_q, state_d;
    logic [IW-1:0]     mem [DEPTH];
    logic [IW-1:0]     fetch_w;
    logic              next_s_q, next_p_q, step_edge;
    logic [PC_W-1:0]   pc_q;
    logic              halted_q, ready_q, zero_q;
    logic [3:0]        op_q;
    logic [WIDTH-1:0]  a_q, b_q, result_q;
    logic              carry_q, borrow_q;
    logic [WIDTH-1:0]  alu_res, alu_res_q, fin_res;
    logic              alu_c, alu_b, alu_c_q, alu_b_q, fin_c, fin_b;

    // next_out is registered once before edge detection, so an edge sampled
    // at clock k is acted upon at clock k+1.
    assign step_edge = next_s_q & ~next_p_q;
    assign fetch_w   = mem[pc_q];

    always_ff @(posedge clk) begin
        if (prog_we && state_q == S_IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    step_alu_core #(.WIDTH(WIDTH)) u_core (
        .op_i     (op_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .res_o    (alu_res),
        .carry_o  (alu_c),
        .borrow_o (alu_b)
    );

`ifdef STEP_ALU_CPU_MUL_EN
    localparam int CNT_W = $clog2(WIDTH + 1);
    logic [2*WIDTH-1:0] mul_acc_q, mul_mcand_q;
    logic [WIDTH-1:0]   mul_mplier_q;
    logic [CNT_W-1:0]   mul_cnt_q;
    logic               mul_busy;

    assign mul_busy = (op_q == OP_MUL) && (mul_cnt_q != CNT_W'(WIDTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_acc_q    <= '0;
            mul_mcand_q  <= '0;
            mul_mplier_q <= '0;
            mul_cnt_q    <= '0;
        end else if (state_q == S_FETCH) begin
            mul_acc_q    <= '0;
            mul_mcand_q  <= {{WIDTH{1'b0}}, fetch_w[A_L +: WIDTH]};
            mul_mplier_q <= fetch_w[B_L +: WIDTH];
            mul_cnt_q    <= '0;
        end else if (state_q == S_EXEC && mul_busy) begin
            if (mul_mplier_q[0]) begin
                mul_acc_q <= mul_acc_q + mul_mcand_q;
            end
            mul_mcand_q  <= {mul_mcand_q[2*WIDTH-2:0], 1'b0};
            mul_mplier_q <= {1'b0, mul_mplier_q[WIDTH-1:1]};
            mul_cnt_q    <= mul_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        fin_res = alu_res_q;
        fin_c   = alu_c_q;
        fin_b   = alu_b_q;
        if (op_q == OP_MUL) begin
            fin_res = mul_acc_q[WIDTH-1:0];
            fin_c   = |mul_acc_q[2*WIDTH-1:WIDTH];
            fin_b   = 1'b0;
        end
    end
`else
    logic mul_busy;
    assign mul_busy = 1'b0;

    always_comb begin
        fin_res = alu_res_q;
        fin_c   = alu_c_q;
        fin_b   = alu_b_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (step_edge && !halted_q) state_d = S_FETCH;
            S_FETCH: state_d = S_EXEC;
            S_EXEC:  if (!mul_busy) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            next_s_q  <= 1'b0;
            next_p_q  <= 1'b0;
            pc_q      <= '0;
            halted_q  <= 1'b0;
            ready_q   <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_res_q <= '0;
            alu_c_q   <= 1'b0;
            alu_b_q   <= 1'b0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            borrow_q  <= 1'b0;
            zero_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            next_s_q <= next_out;
            next_p_q <= next_s_q;
            ready_q  <= 1'b0;
            case (state_q)
                S_FETCH: begin
                    op_q <= fetch_w[OP_L +: 4];
                    a_q  <= fetch_w[A_L +: WIDTH];
                    b_q  <= fetch_w[B_L +: WIDTH];
                end
                S_EXEC: begin
                    alu_res_q <= alu_res;
                    alu_c_q   <= alu_c;
                    alu_b_q   <= alu_b;
                end
                S_DONE: begin
                    if (op_q == OP_HALT) begin
                        halted_q <= 1'b1;
                    end else begin
                        result_q <= fin_res;
                        carry_q  <= fin_c;
                        borrow_q <= fin_b;
                        zero_q   <= (fin_res == '0);
                        ready_q  <= 1'b1;
                        pc_q     <= pc_q + PC_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign opcode        = op_q;
    assign operand_A_out = a_q;
    assign operand_B_out = b_q;
    assign result_out    = result_q;
    assign carry_out     = carry_q;
    assign borrow_out    = borrow_q;
    assign data_out      = zero_q;
    assign result_ready  = ready_q;
    assign pc_out        = pc_q;
    assign halted        = halted_q;

endmodule

// File: tb/tb_step_alu_cpu.sv
// Scoreboard bench for step_alu_cpu (WIDTH=8, DEPTH=4); honours STEP_ALU_CPU_MUL_EN.
module tb_step_alu_cpu;

    localparam int W   = 8;
    localparam int D   = 4;
    localparam int WIN = 24;

    typedef struct {
        logic [7:0] res;
        logic       c;
        logic       b;
        logic       z;
        logic [1:0] pc;
        int         lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        next_out = 1'b0;
    logic        prog_we = 1'b0;
    logic [1:0]  prog_addr = '0;
    logic [19:0] prog_data = '0;
    logic [3:0]  opcode;
    logic [7:0]  operand_A_out, operand_B_out, result_out;
    logic        carry_out, borrow_out, data_out, result_ready, halted;
    logic [1:0]  pc_out;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb_q[$];
    logic [19:0] shadow [D];
    logic [1:0]  exp_pc;
    logic        halted_m;
    logic [7:0]  last_res;
    logic        last_c, last_b, last_z;

    step_alu_cpu #(.WIDTH(W), .DEPTH(D)) dut (
        .clk           (clk),
        .rst           (rst),
        .next_out      (next_out),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .opcode        (opcode),
        .operand_A_out (operand_A_out),
        .operand_B_out (operand_B_out),
        .result_out    (result_out),
        .carry_out     (carry_out),
        .borrow_out    (borrow_out),
        .data_out      (data_out),
        .result_ready  (result_ready),
        .pc_out        (pc_out),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] mk(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        return {op, a, b};
    endfunction

    // Reference model; edge sampled at k -> result_ready seen after edge k+4.
    function automatic exp_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        exp_t        m;
        logic [8:0]  s;
        logic [15:0] p;
        m.res = 8'h00; m.c = 1'b0; m.b = 1'b0; m.pc = 2'd0; m.lat = 4;
        s = {1'b0, a} + {1'b0, b};
        p = 16'(a) * 16'(b);
        case (op)
            4'h0: begin m.res = s[7:0]; m.c = s[8]; end
            4'h1: begin m.res = a - b; m.b = (a < b); end
            4'h2: m.res = a & b;
            4'h3: m.res = a | b;
            4'h4: m.res = a ^ b;
            4'h5: m.res = ~a;
            4'h6: begin m.res = a << 1; m.c = a[7]; end
            4'h7: begin m.res = a >> 1; m.c = a[0]; end
`ifdef STEP_ALU_CPU_MUL_EN
            4'h8: begin m.res = p[7:0]; m.c = (p[15:8] != 8'h00); m.lat = 4 + W; end
`endif
            default: ;
        endcase
        m.z = (m.res == 8'h00);
        return m;
    endfunction

    task automatic write_word(input logic [1:0] addr, input logic [19:0] word);
        @(negedge clk);
        prog_we = 1'b1; prog_addr = addr; prog_data = word;
        @(negedge clk);
        prog_we = 1'b0;
        shadow[addr] = word;
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_pc"}, 32'(pc_out), 0);
        check_eq({tag, "_halted"}, 32'(halted), 0);
        check_eq({tag, "_ready"}, 32'(result_ready), 0);
        check_eq({tag, "_opcode"}, 32'(opcode), 0);
        check_eq({tag, "_opA"}, 32'(operand_A_out), 0);
        check_eq({tag, "_opB"}, 32'(operand_B_out), 0);
        check_eq({tag, "_result"}, 32'(result_out), 0);
        check_eq({tag, "_carry"}, 32'(carry_out), 0);
        check_eq({tag, "_borrow"}, 32'(borrow_out), 0);
        check_eq({tag, "_zero"}, 32'(data_out), 1);
    endtask

    task automatic model_reset();
        exp_pc = 2'd0; halted_m = 1'b0;
        last_res = 8'h00; last_c = 1'b0; last_b = 1'b0; last_z = 1'b1;
        sb_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; next_out = 1'b0; prog_we = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // One step: optional mid-instruction re-edge (glitch), write while busy (poke),
    // or write to pc in the same cycle as the step edge (same_wr).
    task automatic step(input string tag, input bit glitch, input bit poke,
                        input bit same_wr, input logic [19:0] same_word);
        exp_t        e, got;
        logic [19:0] w;
        logic        was_halted, no_result;
        int          rdy_cnt;
        @(negedge clk);
        if (same_wr) begin
            prog_we = 1'b1; prog_addr = exp_pc; prog_data = same_word;
            shadow[exp_pc] = same_word;
        end
        next_out   = 1'b1;
        was_halted = halted_m;
        w          = shadow[exp_pc];
        e          = model(w[19:16], w[15:8], w[7:0]);
        no_result  = was_halted || (w[19:16] == 4'hF);
        if (!no_result) begin
            e.pc = exp_pc + 2'd1;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1 prog_we = 1'b0;
        rdy_cnt = 0;
        for (int c = 1; c <= WIN; c++) begin
            @(posedge clk);
            #1;
            if (result_ready) begin
                rdy_cnt++;
                if (rdy_cnt == 1) begin
                    if (sb_q.size() == 0) begin
                        check_eq({tag, "_unexpected_ready"}, 1, 0);
                    end else begin
                        got = sb_q.pop_front();
                        check_eq({tag, "_lat"}, 32'(c), 32'(got.lat));
                        check_eq({tag, "_result"}, 32'(result_out), 32'(got.res));
                        check_eq({tag, "_carry"}, 32'(carry_out), 32'(got.c));
                        check_eq({tag, "_borrow"}, 32'(borrow_out), 32'(got.b));
                        check_eq({tag, "_zero"}, 32'(data_out), 32'(got.z));
                        check_eq({tag, "_pc"}, 32'(pc_out), 32'(got.pc));
                        last_res = got.res; last_c = got.c; last_b = got.b; last_z = got.z;
                    end
                end
            end
            if (glitch && c == 1) next_out = 1'b0;
            if (glitch && c == 2) next_out = 1'b1;
            if (poke && c == 1) begin
                prog_we = 1'b1; prog_addr = exp_pc + 2'd1; prog_data = 20'hABCDE;
            end
            if (poke && c == 2) prog_we = 1'b0;
            if (c == 16) next_out = 1'b0;
        end
        sb_q.delete();
        check_eq({tag, "_nready"}, 32'(rdy_cnt), no_result ? 0 : 1);
        if (!no_result) exp_pc = exp_pc + 2'd1;
        if (!was_halted && w[19:16] == 4'hF) halted_m = 1'b1;
        if (!was_halted) begin
            check_eq({tag, "_opcode"}, 32'(opcode), 32'(w[19:16]));
            check_eq({tag, "_opA"}, 32'(operand_A_out), 32'(w[15:8]));
            check_eq({tag, "_opB"}, 32'(operand_B_out), 32'(w[7:0]));
        end
        check_eq({tag, "_hold_result"}, 32'(result_out), 32'(last_res));
        check_eq({tag, "_hold_carry"}, 32'(carry_out), 32'(last_c));
        check_eq({tag, "_hold_borrow"}, 32'(borrow_out), 32'(last_b));
        check_eq({tag, "_hold_zero"}, 32'(data_out), 32'(last_z));
        check_eq({tag, "_hold_pc"}, 32'(pc_out), 32'(exp_pc));
        check_eq({tag, "_halted"}, 32'(halted), 32'(halted_m));
        $display("step %-14s op=%h A=%h B=%h -> result=%h c=%b b=%b z=%b pc=%0d ready_pulses=%0d",
                 tag, w[19:16], w[15:8], w[7:0], result_out, carry_out, borrow_out,
                 data_out, pc_out, rdy_cnt);
    endtask

    task automatic reset_during_exec();
        int rdy_cnt;
        write_word(exp_pc, mk(4'h8, 8'h10, 8'h10));
        @(negedge clk);
        next_out = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; next_out = 1'b0;
        @(posedge clk);
        #1 check_reset_vals("rst_exec");
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        rdy_cnt = 0;
        for (int c = 0; c < WIN; c++) begin
            @(posedge clk);
            #1 if (result_ready) rdy_cnt++;
        end
        check_eq("rst_exec_nready", 32'(rdy_cnt), 0);
        $display("reset during EXEC: ready_pulses=%0d pc=%0d", rdy_cnt, pc_out);
    endtask

    initial begin
        model_reset();
        do_reset();
        #1 check_reset_vals("reset");

        write_word(2'd0, mk(4'h0, 8'h7F, 8'h01));
        write_word(2'd1, mk(4'h1, 8'h03, 8'h05));
        write_word(2'd2, mk(4'h4, 8'h55, 8'h55));
        write_word(2'd3, mk(4'h6, 8'h81, 8'h00));
        step("add", 0, 0, 0, '0);
        step("sub", 0, 0, 0, '0);
        step("xor", 0, 0, 0, '0);
        step("shl_wrap", 0, 0, 0, '0);
        step("add_glitch", 1, 1, 0, '0);
        step("sub_unpoked", 0, 0, 0, '0);
        step("same_cyc_wr", 0, 0, 1, mk(4'h2, 8'hF0, 8'h3C));
        write_word(2'd3, mk(4'h5, 8'h0F, 8'h00));
        write_word(2'd0, mk(4'h7, 8'h81, 8'h00));
        write_word(2'd1, mk(4'h3, 8'hA0, 8'h05));
        step("not", 0, 0, 0, '0);
        step("shr", 0, 0, 0, '0);
        step("or", 0, 0, 0, '0);

        reset_during_exec();

        write_word(2'd0, mk(4'h9, 8'h12, 8'h34));
        write_word(2'd1, mk(4'hA, 8'hFF, 8'h01));
        write_word(2'd2, mk(4'hC, 8'h80, 8'h80));
        write_word(2'd3, mk(4'hE, 8'h01, 8'hFF));
        for (int i = 0; i < 4; i++) step($sformatf("nop%0d", i), 0, 0, 0, '0);

        write_word(2'd0, mk(4'h8, 8'h10, 8'h10));
        write_word(2'd1, mk(4'h8, 8'h0F, 8'h0D));
        step("mul_ovf", 0, 0, 0, '0);
        step("mul_small", 0, 0, 0, '0);

        write_word(2'd2, mk(4'hF, 8'h11, 8'h22));
        step("halt", 0, 0, 0, '0);
        for (int i = 0; i < 3; i++) step($sformatf("halted%0d", i), 0, 0, 0, '0);
        do_reset();
        #1 check_eq("halt_cleared", 32'(halted), 0);
        check_eq("halt_cleared_pc", 32'(pc_out), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
